// File: rtl/subarray_pkg.sv
// Shared types and sizing helpers for the subarray fetch/pack sequencer.
package subarray_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_PUSH,
        S_DONE
    } state_t;

    localparam int DEF_SIZE_DATA     = 8;
    localparam int DEF_ADDR_ROM      = 16;
    localparam int DEF_SIZE_SUBARRAY = 32;
    localparam int DEF_TOTAL_ELEM    = 65536;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // A one-lane word still needs a 1-bit lane counter.
    function automatic int lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NUM_SUBARRAY = ceil_div(DEF_TOTAL_ELEM, DEF_SIZE_SUBARRAY);
    localparam int LANE_W       = lane_w(DEF_SIZE_SUBARRAY);
    localparam int CNT_W        = DEF_ADDR_ROM + 1;

endpackage

// File: rtl/subarray_packer.sv
// Lane register: drops each captured element into the next lane of the word.
module subarray_packer
    import subarray_pkg::*;
#(
    parameter int SIZE_DATA     = DEF_SIZE_DATA,
    parameter int SIZE_SUBARRAY = DEF_SIZE_SUBARRAY,
    parameter int LANE_W        = lane_w(SIZE_SUBARRAY)
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_clr,
    input  logic                              i_wr_en,
    input  logic [SIZE_DATA-1:0]              i_data,
    output logic [SIZE_DATA*SIZE_SUBARRAY-1:0] o_data
);

    logic [LANE_W-1:0] lane;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data <= '0;
            lane   <= '0;
        end else if (i_clr) begin
            o_data <= '0;
            lane   <= '0;
        end else if (i_wr_en) begin
            for (int k = 0; k < SIZE_SUBARRAY; k++) begin
                if (lane == LANE_W'(k)) begin
                    o_data[k*SIZE_DATA +: SIZE_DATA] <= i_data;
                end
            end
            lane <= lane + 1'b1;
        end
    end

endmodule

// File: rtl/subarray_fetch_ctrl.sv
// Streams elements out of the ROM, packs them into subarray words and
// pushes each word into the FIFO, zero-padding the final partial word.
module subarray_fetch_ctrl
    import subarray_pkg::*;
#(
    parameter int SIZE_DATA     = DEF_SIZE_DATA,
    parameter int ADDR_ROM      = DEF_ADDR_ROM,
    parameter int SIZE_SUBARRAY = DEF_SIZE_SUBARRAY,
    parameter int TOTAL_ELEM    = DEF_TOTAL_ELEM
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_start,
    input  logic [SIZE_DATA-1:0]              i_rom_data,
    output logic                              o_rom_rd_en,
    output logic [ADDR_ROM-1:0]               o_rom_addr,
    input  logic                              i_fifo_full,
    output logic                              o_fifo_wr_en,
    output logic [SIZE_DATA*SIZE_SUBARRAY-1:0] o_fifo_data,
    output logic [ADDR_ROM:0]                 o_subarray_cnt,
    output logic                              o_busy,
    output logic                              o_done
);

    localparam int LW = lane_w(SIZE_SUBARRAY);
    localparam int CW = ADDR_ROM + 1;
    localparam int RW = LW + 1;
    localparam logic [CW-1:0] TOTAL    = CW'(TOTAL_ELEM);
    localparam logic [RW-1:0] WORD_LEN = RW'(SIZE_SUBARRAY);

    state_t        state;
    logic [CW-1:0] elem_cnt;
    logic [RW-1:0] rd_cnt;
    logic          rd_q;
    logic          pack_clr;
    logic          more;

    // elem_cnt counts reads already issued, including the one on the bus.
    assign more         = (elem_cnt != TOTAL);
    assign o_fifo_wr_en = (state == S_PUSH) & ~i_fifo_full;
    assign pack_clr     = ((state == S_IDLE) & i_start)
                        | (o_fifo_wr_en & more);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= S_IDLE;
            elem_cnt       <= '0;
            rd_cnt         <= '0;
            rd_q           <= 1'b0;
            o_rom_rd_en    <= 1'b0;
            o_rom_addr     <= '0;
            o_subarray_cnt <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            rd_q   <= o_rom_rd_en;
            o_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state          <= S_FETCH;
                        o_rom_rd_en    <= 1'b1;
                        o_rom_addr     <= '0;
                        elem_cnt       <= CW'(1);
                        rd_cnt         <= RW'(1);
                        o_subarray_cnt <= '0;
                        o_busy         <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (!more || rd_cnt == WORD_LEN) begin
                        state       <= S_DRAIN;
                        o_rom_rd_en <= 1'b0;
                    end else begin
                        o_rom_addr <= elem_cnt[ADDR_ROM-1:0];
                        elem_cnt   <= elem_cnt + 1'b1;
                        rd_cnt     <= rd_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    state <= S_PUSH;
                end
                S_PUSH: begin
                    if (!i_fifo_full) begin
                        o_subarray_cnt <= o_subarray_cnt + 1'b1;
                        if (more) begin
                            state       <= S_FETCH;
                            o_rom_rd_en <= 1'b1;
                            o_rom_addr  <= elem_cnt[ADDR_ROM-1:0];
                            elem_cnt    <= elem_cnt + 1'b1;
                            rd_cnt      <= RW'(1);
                        end else begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Data requested in one cycle lands in the packer the next cycle.
    subarray_packer #(
        .SIZE_DATA    (SIZE_DATA),
        .SIZE_SUBARRAY(SIZE_SUBARRAY),
        .LANE_W       (LW)
    ) u_packer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (pack_clr),
        .i_wr_en(rd_q),
        .i_data (i_rom_data),
        .o_data (o_fifo_data)
    );

endmodule

// File: tb/tb_subarray_fetch_ctrl.sv
// Randomised bench for subarray_fetch_ctrl against a word-level timing model.
`timescale 1ns/1ps
module tb_subarray_fetch_ctrl;

    localparam int SD    = 8;
    localparam int AR    = 16;
    localparam int S     = 4;
    localparam int TOT   = 10;
    localparam int TOT_B = 8;
    localparam int DW    = SD * S;
    localparam int CW    = AR + 1;
    localparam int NUM   = (TOT + S - 1) / S;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          full = 1'b0;
    logic          start_b = 1'b0;
    logic          full_b = 1'b0;
    logic [SD-1:0] rom_a = '0;
    logic [SD-1:0] rom_b = '0;

    logic          rd_en, wr_en, busy, done;
    logic [AR-1:0] addr;
    logic [DW-1:0] data;
    logic [CW-1:0] cnt;
    logic          rd_en_b, wr_en_b, busy_b, done_b;
    logic [AR-1:0] addr_b;
    logic [DW-1:0] data_b;
    logic [CW-1:0] cnt_b;

    int errors = 0;
    int checks = 0;

    subarray_fetch_ctrl #(
        .SIZE_DATA(SD), .ADDR_ROM(AR), .SIZE_SUBARRAY(S), .TOTAL_ELEM(TOT)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_rom_data(rom_a),
        .o_rom_rd_en(rd_en), .o_rom_addr(addr), .i_fifo_full(full),
        .o_fifo_wr_en(wr_en), .o_fifo_data(data), .o_subarray_cnt(cnt),
        .o_busy(busy), .o_done(done)
    );

    subarray_fetch_ctrl #(
        .SIZE_DATA(SD), .ADDR_ROM(AR), .SIZE_SUBARRAY(S), .TOTAL_ELEM(TOT_B)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_rom_data(rom_b),
        .o_rom_rd_en(rd_en_b), .o_rom_addr(addr_b), .i_fifo_full(full_b),
        .o_fifo_wr_en(wr_en_b), .o_fifo_data(data_b), .o_subarray_cnt(cnt_b),
        .o_busy(busy_b), .o_done(done_b)
    );

    always #5 clk = ~clk;

    // ROM content is the low byte of the address, one cycle latency.
    always @(posedge clk) begin
        if (rd_en)   rom_a <= addr[7:0];
        if (rd_en_b) rom_b <= addr_b[7:0];
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int nread(input int k);
        return (TOT - k * S < S) ? TOT - k * S : S;
    endfunction

    function automatic logic [DW-1:0] word(input int k);
        logic [DW-1:0] w;
        w = '0;
        for (int j = 0; j < S; j++) begin
            if (k * S + j < TOT) w[j*SD +: SD] = SD'(k * S + j);
        end
        return w;
    endfunction

    // Model: word k is read in the n_k cycles after the previous write
    // (or the start), then pushed 2 cycles later once the FIFO has room.
    int mode = -1;
    int t = 0;
    int t0 = 0;
    int k = 0;
    int pw = 0;
    int last_addr = 0;
    int rec_wr_c[$];
    logic [DW-1:0] rec_wr_d[$];
    int rec_rd[$];
    int rec_done = -1;

    always @(negedge clk) begin
        int rt, n, ea;
        bit rd_x, push_x, wr_x, done_x;
        t++;
        if (rst) begin
            mode = 0;
            last_addr = 0;
        end
        if (mode == 0 || mode == 2) begin
            chk("idle rd_en", rd_en, 0);
            chk("idle rom_addr", addr, last_addr);
            chk("idle wr_en", wr_en, 0);
            chk("idle fifo_data", data,
                (mode == 0) ? {DW{1'b0}} : word(NUM - 1));
            chk("idle subarray_cnt", cnt, (mode == 0) ? 0 : NUM);
            chk("idle busy", busy, 0);
            chk("idle done", done, 0);
        end else if (mode == 1) begin
            rt     = t - t0;
            n      = (k < NUM) ? nread(k) : 0;
            rd_x   = (k < NUM) && rt >= pw + 1 && rt <= pw + n;
            ea     = rd_x ? k * S + rt - pw - 1 : last_addr;
            push_x = (k < NUM) && rt >= pw + n + 2;
            wr_x   = push_x && !full;
            done_x = (k == NUM) && rt == pw + 1;
            chk("rd_en", rd_en, rd_x);
            chk("rom_addr", addr, ea);
            chk("wr_en", wr_en, wr_x);
            if (push_x) chk("fifo_data", data, word(k));
            chk("subarray_cnt", cnt, k);
            chk("busy", busy, k < NUM);
            chk("done", done, done_x);
            if (rd_en) rec_rd.push_back(int'(addr));
            if (wr_en) begin
                rec_wr_c.push_back(rt);
                rec_wr_d.push_back(data);
            end
            if (done) rec_done = rt;
            if (rd_x) last_addr = ea;
            if (wr_x) begin
                pw = rt;
                k++;
            end
            if (done_x) mode = 2;
        end
        if (mode != 1 && mode >= 0 && !rst && start) begin
            mode = 1;
            t0 = t;
            k = 0;
            pw = 0;
        end
    end

    task automatic run(input int full_lo, input int full_hi,
                       input int again, input int abort_at, input bit rnd);
        bit found;
        found = 0;
        rec_wr_c.delete();
        rec_wr_d.delete();
        rec_rd.delete();
        rec_done = -1;
        start = 1'b1;
        full = 1'b0;
        for (int c = 1; c < 400 && !found; c++) begin
            tick();
            if (done) begin
                found = 1;
            end else if (c == abort_at) begin
                start = 1'b0;
                full = 1'b0;
                rst = 1'b1;
                tick();
                tick();
                rst = 1'b0;
                found = 1;
            end else begin
                start = (c == again) || (rnd && $urandom_range(15) == 0);
                full = (c >= full_lo && c <= full_hi)
                    || (rnd && $urandom_range(2) == 0);
            end
        end
        start = 1'b0;
        full = 1'b0;
        chk("run terminates", found, 1);
        tick();
        tick();
    endtask

    task automatic check_s2(input string tag);
        chk({tag, " writes"}, rec_wr_c.size(), 3);
        chk({tag, " wr0 cycle"}, rec_wr_c[0], 6);
        chk({tag, " wr1 cycle"}, rec_wr_c[1], 12);
        chk({tag, " wr2 cycle"}, rec_wr_c[2], 16);
        chk({tag, " wr0 data"}, rec_wr_d[0], 32'h03020100);
        chk({tag, " wr1 data"}, rec_wr_d[1], 32'h07060504);
        chk({tag, " wr2 data"}, rec_wr_d[2], 32'h00000908);
        chk({tag, " done cycle"}, rec_done, 17);
        chk({tag, " reads"}, rec_rd.size(), 10);
        for (int i = 0; i < rec_rd.size(); i++) begin
            chk({tag, " read addr"}, rec_rd[i], i);
        end
        chk({tag, " final cnt"}, cnt, 3);
    endtask

    initial begin
        int nb, db;
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();
        chk("s1 busy", busy, 0);
        chk("s1 cnt", cnt, 0);
        chk("s1 data", data, 0);
        chk("s1 addr", addr, 0);

        run(1000, 0, -1, -1, 0);
        check_s2("s2");

        run(6, 10, -1, -1, 0);
        chk("s3 writes", rec_wr_c.size(), 3);
        chk("s3 wr0 cycle", rec_wr_c[0], 11);
        chk("s3 wr0 data", rec_wr_d[0], 32'h03020100);
        chk("s3 done cycle", rec_done, 22);

        run(1000, 0, 3, -1, 0);
        check_s2("s4a");
        run(1000, 0, -1, -1, 0);
        check_s2("s4b");

        run(1000, 0, -1, 8, 0);
        chk("s5 writes before abort", rec_wr_c.size(), 1);
        chk("s5 cnt after abort", cnt, 0);
        chk("s5 busy after abort", busy, 0);
        run(1000, 0, -1, -1, 0);
        check_s2("s5");

        nb = 0;
        db = -1;
        start_b = 1'b1;
        for (int c = 1; c < 60 && db < 0; c++) begin
            tick();
            start_b = 1'b0;
            if (wr_en_b) begin
                if (nb == 0) chk("s6 wr0 cycle", c, 6);
                else chk("s6 wr1 cycle", c, 12);
                nb++;
            end
            if (done_b) db = c;
        end
        chk("s6 writes", nb, 2);
        chk("s6 done cycle", db, 13);
        chk("s6 last data", data_b, 32'h07060504);
        chk("s6 cnt", cnt_b, 2);

        for (int r = 0; r < 20; r++) begin
            run(1000, 0, -1, -1, 1);
            chk("rand writes", rec_wr_c.size(), NUM);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
